// File: rtl/reflection_hw_pkg.sv
// rtl/reflection_hw_pkg.sv - shared status codes, FSM states and widths for the reflection responder
package reflection_hw_pkg;

  localparam int STATUS_WIDTH = 2;

  typedef enum logic [STATUS_WIDTH-1:0] {
    OK          = 2'd0,
    NO_SUCH_VAR = 2'd1,
    READ_ONLY   = 2'd2,
    BAD_LENGTH  = 2'd3
  } rf_status_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_COLLECT = 3'd1,
    WR_DRAIN   = 3'd2,
    RSP_SINGLE = 3'd3,
    RD_STREAM  = 3'd4
  } rf_state_e;

endpackage

// File: rtl/rf_variable_store.sv
// rtl/rf_variable_store.sv - variable register array with one bus write port and per-variable hw write ports
module rf_variable_store
  import reflection_hw_pkg::*;
#(
  parameter int NUM_VARS  = 8,
  parameter int ID_WIDTH  = 4,
  parameter int VAR_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bus_wr_en,
  input  logic [ID_WIDTH-1:0]           bus_wr_id,
  input  logic [VAR_WIDTH-1:0]          bus_wr_data,
  input  logic [NUM_VARS-1:0]           hw_wr_en,
  input  logic [NUM_VARS*VAR_WIDTH-1:0] hw_wr_data,
  output logic [NUM_VARS*VAR_WIDTH-1:0] var_value
);

  logic [NUM_VARS*VAR_WIDTH-1:0] mem_q;
  logic [NUM_VARS*VAR_WIDTH-1:0] mem_d;

  // Bus write is applied after the hw write so it wins on a same-cycle collision.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (hw_wr_en[i]) begin
        mem_d[i*VAR_WIDTH +: VAR_WIDTH] = hw_wr_data[i*VAR_WIDTH +: VAR_WIDTH];
      end
      if (bus_wr_en && (32'(bus_wr_id) == i)) begin
        mem_d[i*VAR_WIDTH +: VAR_WIDTH] = bus_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign var_value = mem_q;

endmodule

// File: rtl/rf_variable_responder.sv
// rtl/rf_variable_responder.sv - GET/SET responder serving multi-beat variable access by ID
module rf_variable_responder
  import reflection_hw_pkg::*;
#(
  parameter int                  NUM_VARS   = 8,
  parameter int                  ID_WIDTH   = 4,
  parameter int                  VAR_WIDTH  = 64,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [NUM_VARS-1:0] RO_MASK    = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ID_WIDTH-1:0]           req_id,
  input  logic [DATA_WIDTH-1:0]         req_data,
  input  logic                          req_last,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_last,
  output logic [STATUS_WIDTH-1:0]       rsp_status,
  input  logic [NUM_VARS-1:0]           hw_wr_en,
  input  logic [NUM_VARS*VAR_WIDTH-1:0] hw_wr_data,
  output logic [NUM_VARS*VAR_WIDTH-1:0] var_value
);

  localparam int BEATS   = VAR_WIDTH / DATA_WIDTH;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ID_SPAN = 2 ** ID_WIDTH;
  // Read-only mask widened to the full ID space so any ID can index it directly.
  localparam logic [ID_SPAN-1:0] RO_EXT = ID_SPAN'(RO_MASK);

  rf_state_e             state_q, state_d;
  rf_status_e            status_q, status_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [VAR_WIDTH-1:0]  collect_q, collect_d;
  logic [VAR_WIDTH-1:0]  snap_q, snap_d;

  logic                  req_fire;
  logic [CNT_W-1:0]      slot;
  logic [VAR_WIDTH-1:0]  collect_fill;
  logic                  commit_en;
  logic [ID_WIDTH-1:0]   commit_id;

  function automatic rf_status_e id_status(input logic [ID_WIDTH-1:0] id);
    if (32'(id) >= NUM_VARS) return NO_SUCH_VAR;
    if (RO_EXT[id]) return READ_ONLY;
    return OK;
  endfunction

  assign req_ready = (state_q == IDLE) || (state_q == WR_COLLECT) || (state_q == WR_DRAIN);
  assign req_fire  = req_valid && req_ready;

  assign rsp_valid  = (state_q == RSP_SINGLE) || (state_q == RD_STREAM);
  assign rsp_data   = (state_q == RD_STREAM) ? snap_q[DATA_WIDTH-1:0] : '0;
  assign rsp_last   = (state_q == RSP_SINGLE) ||
                      ((state_q == RD_STREAM) && (32'(cnt_q) == BEATS - 1));
  assign rsp_status = (state_q == RSP_SINGLE) ? status_q : OK;

  // The incoming beat lands in slot 0 on the first beat, slot cnt afterwards.
  always_comb begin
    slot         = (state_q == IDLE) ? '0 : cnt_q;
    collect_fill = collect_q;
    for (int b = 0; b < BEATS; b++) begin
      if (32'(slot) == b) begin
        collect_fill[b*DATA_WIDTH +: DATA_WIDTH] = req_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    collect_d = collect_q;
    snap_d    = snap_q;
    commit_en = 1'b0;
    commit_id = id_q;

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          cnt_d = '0;
          if (!req_write) begin
            if (32'(req_id) < NUM_VARS) begin
              for (int v = 0; v < NUM_VARS; v++) begin
                if (32'(req_id) == v) snap_d = var_value[v*VAR_WIDTH +: VAR_WIDTH];
              end
              status_d = OK;
              state_d  = RD_STREAM;
            end else begin
              status_d = NO_SUCH_VAR;
              state_d  = RSP_SINGLE;
            end
          end else begin
            id_d      = req_id;
            status_d  = id_status(req_id);
            collect_d = collect_fill;
            if (BEATS == 1) begin
              if (req_last) begin
                commit_en = (id_status(req_id) == OK);
                commit_id = req_id;
                state_d   = RSP_SINGLE;
              end else begin
                state_d = WR_DRAIN;
              end
            end else if (req_last) begin
              status_d = BAD_LENGTH;
              state_d  = RSP_SINGLE;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = WR_COLLECT;
            end
          end
        end
      end

      WR_COLLECT: begin
        if (req_fire) begin
          collect_d = collect_fill;
          cnt_d     = cnt_q + 1'b1;
          if (req_last) begin
            if (32'(cnt_q) < BEATS - 1) begin
              status_d = BAD_LENGTH;
            end else begin
              commit_en = (status_q == OK);
            end
            state_d = RSP_SINGLE;
          end else if (32'(cnt_q) == BEATS - 1) begin
            state_d = WR_DRAIN;
          end
        end
      end

      WR_DRAIN: begin
        if (req_fire && req_last) begin
          status_d = BAD_LENGTH;
          state_d  = RSP_SINGLE;
        end
      end

      RSP_SINGLE: begin
        if (rsp_ready) state_d = IDLE;
      end

      RD_STREAM: begin
        if (rsp_ready) begin
          snap_d = snap_q >> DATA_WIDTH;
          cnt_d  = cnt_q + 1'b1;
          if (32'(cnt_q) == BEATS - 1) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      status_q  <= OK;
      id_q      <= '0;
      cnt_q     <= '0;
      collect_q <= '0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      collect_q <= collect_d;
      snap_q    <= snap_d;
    end
  end

  rf_variable_store #(
    .NUM_VARS (NUM_VARS),
    .ID_WIDTH (ID_WIDTH),
    .VAR_WIDTH(VAR_WIDTH)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .bus_wr_en  (commit_en),
    .bus_wr_id  (commit_id),
    .bus_wr_data(collect_fill),
    .hw_wr_en   (hw_wr_en),
    .hw_wr_data (hw_wr_data),
    .var_value  (var_value)
  );

endmodule

// File: tb/tb_rf_variable_responder.sv
// tb/tb_rf_variable_responder.sv - directed self-checking bench for rf_variable_responder
module tb_rf_variable_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [3:0]   req_id;
  logic [31:0]  req_data;
  logic         req_last;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_last;
  logic [1:0]   rsp_status;
  logic [7:0]   hw_wr_en;
  logic [511:0] hw_wr_data;
  logic [511:0] var_value;
  logic [511:0] exp_vars;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_variable_responder #(
    .NUM_VARS  (8),
    .ID_WIDTH  (4),
    .VAR_WIDTH (64),
    .DATA_WIDTH(32),
    .RO_MASK   (8'h08)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_id    (req_id),
    .req_data  (req_data),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_status(rsp_status),
    .hw_wr_en  (hw_wr_en),
    .hw_wr_data(hw_wr_data),
    .var_value (var_value)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic w, input logic [3:0] id, input logic [31:0] d, input logic l);
    req_valid = 1'b1;
    req_write = w;
    req_id    = id;
    req_data  = d;
    req_last  = l;
    chk("req_ready", 512'(req_ready), 512'(1));
    step();
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [31:0] d,
                           input logic l, input logic [1:0] s);
    chk({tag, ".valid"}, 512'(rsp_valid), 512'(v));
    chk({tag, ".data"}, 512'(rsp_data), 512'(d));
    chk({tag, ".last"}, 512'(rsp_last), 512'(l));
    chk({tag, ".status"}, 512'(rsp_status), 512'(s));
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, ".idle"}, 512'(rsp_valid), 512'(0));
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_id     = '0;
    req_data   = '0;
    req_last   = 1'b0;
    rsp_ready  = 1'b0;
    hw_wr_en   = '0;
    hw_wr_data = '0;
    exp_vars   = '0;
    step();
    step();
    rst = 1'b0;
    check_rsp("reset", 1'b0, 32'h0, 1'b0, 2'd0);
    chk("reset.vars", var_value, exp_vars);
    chk("reset.req_ready", 512'(req_ready), 512'(1));

    // SET id 2, two beats
    beat(1'b1, 4'd2, 32'hDEADBEEF, 1'b0);
    chk("set2.no_early_rsp", 512'(rsp_valid), 512'(0));
    beat(1'b1, 4'd2, 32'h01234567, 1'b1);
    exp_vars[2*64 +: 64] = 64'h01234567_DEADBEEF;
    check_rsp("set2.rsp", 1'b1, 32'h0, 1'b1, 2'd0);
    chk("set2.vars", var_value, exp_vars);
    chk("set2.req_ready_busy", 512'(req_ready), 512'(0));
    consume("set2");

    // GET id 2, back-to-back beats
    rsp_ready = 1'b1;
    beat(1'b0, 4'd2, 32'h0, 1'b0);
    check_rsp("get2.b0", 1'b1, 32'hDEADBEEF, 1'b0, 2'd0);
    step();
    check_rsp("get2.b1", 1'b1, 32'h01234567, 1'b1, 2'd0);
    step();
    chk("get2.done", 512'(rsp_valid), 512'(0));
    rsp_ready = 1'b0;

    // SET read-only var 3
    beat(1'b1, 4'd3, 32'h11111111, 1'b0);
    beat(1'b1, 4'd3, 32'h22222222, 1'b1);
    check_rsp("set3.ro", 1'b1, 32'h0, 1'b1, 2'd2);
    chk("set3.vars", var_value, exp_vars);
    consume("set3");

    // GET invalid id 9
    beat(1'b0, 4'd9, 32'h0, 1'b0);
    check_rsp("get9", 1'b1, 32'h0, 1'b1, 2'd1);
    consume("get9");

    // SET invalid id 12, full length
    beat(1'b1, 4'd12, 32'hCAFEF00D, 1'b0);
    chk("set12.collecting", 512'(rsp_valid), 512'(0));
    beat(1'b1, 4'd12, 32'hBAADF00D, 1'b1);
    check_rsp("set12", 1'b1, 32'h0, 1'b1, 2'd1);
    chk("set12.vars", var_value, exp_vars);
    consume("set12");

    // SET id 1 too short, then too long
    beat(1'b1, 4'd1, 32'h0000AAAA, 1'b1);
    check_rsp("set1.short", 1'b1, 32'h0, 1'b1, 2'd3);
    consume("set1.short");
    beat(1'b1, 4'd1, 32'h00000001, 1'b0);
    beat(1'b1, 4'd1, 32'h00000002, 1'b0);
    chk("set1.long.draining", 512'(rsp_valid), 512'(0));
    beat(1'b1, 4'd1, 32'h00000003, 1'b1);
    check_rsp("set1.long", 1'b1, 32'h0, 1'b1, 2'd3);
    chk("set1.vars", var_value, exp_vars);
    consume("set1.long");

    // Bus commit and hw write to var 4 in the same cycle
    beat(1'b1, 4'd4, 32'hAAAAAAAA, 1'b0);
    hw_wr_en               = 8'h10;
    hw_wr_data[4*64 +: 64] = 64'h55555555_55555555;
    beat(1'b1, 4'd4, 32'hAAAAAAAA, 1'b1);
    hw_wr_en = '0;
    exp_vars[4*64 +: 64] = 64'hAAAAAAAA_AAAAAAAA;
    chk("collide4.vars", var_value, exp_vars);
    consume("collide4");

    // hw write ignores RO_MASK
    hw_wr_en               = 8'h08;
    hw_wr_data[3*64 +: 64] = 64'h33333333_00000033;
    step();
    hw_wr_en = '0;
    exp_vars[3*64 +: 64] = 64'h33333333_00000033;
    chk("hw3.vars", var_value, exp_vars);

    // GET id 2 with a concurrent hw write and stalls
    beat(1'b0, 4'd2, 32'h0, 1'b0);
    hw_wr_en               = 8'h04;
    hw_wr_data[2*64 +: 64] = 64'hFFFFFFFF_FFFFFFFF;
    step();
    hw_wr_en = '0;
    exp_vars[2*64 +: 64] = 64'hFFFFFFFF_FFFFFFFF;
    chk("snap.vars", var_value, exp_vars);
    check_rsp("snap.stall0", 1'b1, 32'hDEADBEEF, 1'b0, 2'd0);
    step();
    check_rsp("snap.stall0b", 1'b1, 32'hDEADBEEF, 1'b0, 2'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_rsp("snap.b1", 1'b1, 32'h01234567, 1'b1, 2'd0);
    step();
    check_rsp("snap.stall1", 1'b1, 32'h01234567, 1'b1, 2'd0);
    consume("snap");

    // Reset in the middle of a SET
    beat(1'b1, 4'd6, 32'h12345678, 1'b0);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    exp_vars = '0;
    chk("rstmid.req_ready", 512'(req_ready), 512'(1));
    check_rsp("rstmid.rsp", 1'b0, 32'h0, 1'b0, 2'd0);
    chk("rstmid.vars", var_value, exp_vars);
    step();
    chk("rstmid.no_stray", 512'(rsp_valid), 512'(0));
    rsp_ready = 1'b1;
    beat(1'b0, 4'd6, 32'h0, 1'b0);
    check_rsp("rstmid.get.b0", 1'b1, 32'h0, 1'b0, 2'd0);
    step();
    check_rsp("rstmid.get.b1", 1'b1, 32'h0, 1'b1, 2'd0);
    step();
    chk("rstmid.get.done", 512'(rsp_valid), 512'(0));
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
